// File: rtl/led_comet_driver.sv
`default_nettype none
// ============================================================================
// Module   : led_comet_driver
// Brief    : Comet head sweeping N_LED outputs with a PWM-dimmed fading trail.
//            Optional ping-pong behaviour compiled in by LED_COMET_BOUNCE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module led_comet_driver #(
  parameter int N_LED       = 8,
  parameter int STEP_CYCLES = 300,
  parameter int PWM_MAX     = 8,
  parameter int DECAY       = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     dir,
  input  logic                     bounce,
  output logic [N_LED-1:0]         led_out,
  output logic [$clog2(N_LED)-1:0] head,
  output logic                     step_pulse
);

  localparam int c_head_w = $clog2(N_LED);
  localparam int c_duty_w = $clog2(PWM_MAX + 1);
  localparam int c_step_w = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

  localparam logic [c_head_w-1:0] c_head_last = c_head_w'(N_LED - 1);
  localparam logic [c_step_w-1:0] c_step_last = c_step_w'(STEP_CYCLES - 1);
  localparam logic [c_duty_w-1:0] c_pwm_max   = c_duty_w'(PWM_MAX);
  localparam logic [c_duty_w-1:0] c_decay     = c_duty_w'(DECAY);

  logic [c_step_w-1:0] r_step_cnt;
  logic [c_duty_w-1:0] r_pwm_cnt;
  logic [c_duty_w-1:0] r_duty [N_LED];
  logic [c_head_w-1:0] r_head;
  logic                r_cur_dir;
  logic [N_LED-1:0]    r_led_out;
  logic                r_step_pulse;

  logic                w_step;
  logic [c_head_w-1:0] w_head_inc;
  logic [c_head_w-1:0] w_head_dec;
  logic [c_head_w-1:0] w_next_head;
  logic                w_next_dir;
  logic [c_duty_w-1:0] w_duty_dec [N_LED];

  assign w_step     = en && (r_step_cnt == c_step_last);
  assign led_out    = r_led_out;
  assign head       = r_head;
  assign step_pulse = r_step_pulse;

  // Step-rate divider: holds while paused so a pending step fires on resume
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_step_cnt <= '0;
    end else if (w_step) begin
      r_step_cnt <= '0;
    end else if (en) begin
      r_step_cnt <= r_step_cnt + c_step_w'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pwm_cnt <= '0;
    end else if (r_pwm_cnt == c_pwm_max) begin
      r_pwm_cnt <= '0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + c_duty_w'(1);
    end
  end

  always_comb begin
    w_head_inc  = (r_head == c_head_last) ? '0 : r_head + c_head_w'(1);
    w_head_dec  = (r_head == '0) ? c_head_last : r_head - c_head_w'(1);
    w_next_head = dir ? w_head_dec : w_head_inc;
    w_next_dir  = dir;
`ifdef LED_COMET_BOUNCE_EN
    // Ping-pong follows the stored direction and reflects off either end
    if (bounce) begin
      w_next_dir = r_cur_dir;
      if (!r_cur_dir) begin
        if (r_head == c_head_last) begin
          w_next_head = c_head_last - c_head_w'(1);
          w_next_dir  = 1'b1;
        end else begin
          w_next_head = r_head + c_head_w'(1);
        end
      end else begin
        if (r_head == '0) begin
          w_next_head = c_head_w'(1);
          w_next_dir  = 1'b0;
        end else begin
          w_next_head = r_head - c_head_w'(1);
        end
      end
    end
`endif
  end

`ifndef LED_COMET_BOUNCE_EN
  logic w_unused;
  assign w_unused = bounce ^ r_cur_dir;
`endif

  always_comb begin
    for (int i = 0; i < N_LED; i++) begin
      if (32'(r_duty[i]) >= DECAY) begin
        w_duty_dec[i] = r_duty[i] - c_decay;
      end else begin
        w_duty_dec[i] = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head       <= '0;
      r_cur_dir    <= 1'b0;
      r_step_pulse <= 1'b0;
      for (int i = 0; i < N_LED; i++) begin
        r_duty[i] <= '0;
      end
    end else begin
      r_step_pulse <= w_step;
      if (w_step) begin
        r_head    <= w_next_head;
        r_cur_dir <= w_next_dir;
        for (int i = 0; i < N_LED; i++) begin
          r_duty[i] <= (c_head_w'(i) == w_next_head) ? c_pwm_max : w_duty_dec[i];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_led_out <= '0;
    end else begin
      for (int i = 0; i < N_LED; i++) begin
        r_led_out[i] <= (r_pwm_cnt < r_duty[i]);
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/led_comet_driver.md
# led_comet_driver

Parametrised successor to the mode-3 water-flow LED driver. It moves a single "comet" head across `N_LED` outputs at a programmable step rate, leaving a PWM-dimmed trail that fades by a fixed decrement per step. Direction is runtime-selectable, and pausing is supported. An optional bounce (ping-pong) mode is available. The block sits in the LED mode bank alongside the other `led_mode` drivers and feeds the board LED mux directly.

## Interface

- `N_LED`, 8: number of LED outputs; must be ≥ 2.
- `STEP_CYCLES`, 300: clk cycles per head step; must be ≥ 1.
- `PWM_MAX`, 8: PWM counter runs 0..`PWM_MAX`, so the period is `PWM_MAX`+1 cycles; head duty = `PWM_MAX`.
- `DECAY`, 2: duty decrement applied per step to every non-head LED, saturating at 0.
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous and active-high.
- `en` in 1: 1 = comet advances; 0 = freeze head and duties (PWM keeps running).
- `dir` in 1: 0 = head index increments, 1 = decrements; ignored while bouncing.
- `bounce` in 1: 1 = ping-pong at the ends (only effective with `LED_COMET_BOUNCE_EN`).
- `led_out` out `N_LED`: registered PWM outputs.
- `head` out `$clog2(N_LED)`: current head index.
- `step_pulse` out 1: one-cycle strobe, high in the cycle after a step event.

## Operation

- Registers:
  - `step_cnt` (0..`STEP_CYCLES`-1)
  - `pwm_cnt` (0..`PWM_MAX`)
  - `duty[N_LED]`, each `$clog2(PWM_MAX+1)` bits
  - `head`
  - `cur_dir`
- Step event: `en`=1 and `step_cnt`==`STEP_CYCLES`-1. On a step event, `step_cnt` goes to 0. Otherwise, if `en`=1, `step_cnt` increments; if `en`=0, `step_cnt` holds.
- On a step event:
  - Compute `next_head` from `head` and the effective direction.
  - `duty[next_head]` <= `PWM_MAX`.
  - Every other `duty[i]` <= (`duty[i]` ≥ `DECAY`) ? `duty[i]`-`DECAY` : 0. The old head decays too.
  - `head` <= `next_head`.
- Wrap mode (bounce inactive):
  - `cur_dir` <= `dir` at each step event, and `dir` is applied to that same step.
  - Increment from `N_LED`-1 gives 0; decrement from 0 gives `N_LED`-1.
- Bounce mode (macro defined and `bounce`=1):
  - Moving up at `N_LED`-1: `next_head` = `N_LED`-2 and `cur_dir` flips to 1.
  - Moving down at 0: `next_head` = 1 and `cur_dir` flips to 0.
  - Otherwise the head moves in `cur_dir`.
  - When `bounce` is deasserted, wrap-mode rules resume at the next step.
- PWM:
  - `pwm_cnt` free-runs regardless of `en`, wrapping from `PWM_MAX` to 0.
  - `led_out[i]` <= (`pwm_cnt` < `duty[i]`).
  - Brightness is `duty`/(`PWM_MAX`+1); duty 0 means always off.
- Trail length is implicit: ceil(`PWM_MAX`/`DECAY`) positions. If `DECAY` ≥ `PWM_MAX`, only the head is lit.

## Timing

- Reset (asynchronous, immediate): `step_cnt`=0, `pwm_cnt`=0, all `duty`=0, `head`=0, `cur_dir`=0, `led_out`=0, `step_pulse`=0.
- With `en` held at 1 from reset release, the first step event occurs on the `STEP_CYCLES`-th rising edge. `head`, `duty` and `step_pulse` update on that edge.
- `led_out` reflects a new `duty` value one clk after the duty update.
- `en` falling in the same cycle as the would-be step: no step, and `step_cnt` holds at `STEP_CYCLES`-1. The step fires on the first cycle `en` returns to 1.
- `dir` or `bounce` changes are sampled only at step events, never mid-step.
- `rst` mid-step or mid-PWM-period: all state clears. The sequence restarts from head 0 on release.

## Configuration

- `LED_COMET_BOUNCE_EN` defined: bounce logic and `cur_dir` flip are compiled in, and `bounce` is honoured.
- Not defined: the `bounce` port still exists but is ignored, and the head always wraps per `dir`. The port list is identical in both builds.

## Test plan

All scenarios use `N_LED`=8, `STEP_CYCLES`=4, `PWM_MAX`=8, `DECAY`=2.

- Reset: assert `rst` asynchronously between edges -> `led_out`=0, `head`=0 and `step_pulse`=0 immediately. Release with `en`=1 -> first `step_pulse` on the 4th edge, `head`=1, `duty[1]`=8.
- Trail: `dir`=0, 4 steps from reset -> `head`=4, duties [4..1] = 8,6,4,2. Over one 9-cycle PWM window, `led_out` high counts are 8,6,4,2 and all others are 0.
- Wrap: `dir`=0 with `head`=7 -> next `head`=0. Switch `dir`=1 at `head`=0 -> next `head`=7, with no extra step.
- Pause: `en`=0 for 100 cycles -> `head` and duties constant, no `step_pulse`, `led_out` keeps toggling. Re-enable -> the step fires on the first enabled cycle if `step_cnt` was at 3.
- Bounce, macro defined, `bounce`=1: head sequence 5,6,7,6,5. With the macro undefined: 5,6,7,0,1.
- Decay floor: `DECAY`=8 override -> only `led_out[head]` ever high, 8 of 9 cycles.
